// File: rtl/bp_be_cache_req_arbiter.sv
// Round-robin arbiter sharing the backend's single D$ miss request channel between
// the D$ miss path (requester 0) and the PTW / uncached path (requester 1).
//
//  state  | meaning
//  e_idle | nothing outstanding; arbitrate, grant on cache_req handshake
//  e_meta | cycle after the handshake; latched metadata is presented
//  e_wait | waiting for the LCE to signal transaction complete
module bp_be_cache_req_arbiter #(
    parameter int req_width_p      = 128,
    parameter int metadata_width_p = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic [req_width_p-1:0]      req0_i,
    input  logic [metadata_width_p-1:0] req0_metadata_i,
    input  logic                        req0_v_i,
    output logic                        req0_yumi_o,
    output logic                        req0_critical_o,
    output logic                        req0_complete_o,

    input  logic [req_width_p-1:0]      req1_i,
    input  logic [metadata_width_p-1:0] req1_metadata_i,
    input  logic                        req1_v_i,
    output logic                        req1_yumi_o,
    output logic                        req1_critical_o,
    output logic                        req1_complete_o,

    output logic [req_width_p-1:0]      cache_req_o,
    output logic                        cache_req_v_o,
    input  logic                        cache_req_ready_i,
    output logic [metadata_width_p-1:0] cache_req_metadata_o,
    output logic                        cache_req_metadata_v_o,
    input  logic                        cache_req_critical_i,
    input  logic                        cache_req_complete_i,

    output logic                        busy_o
);

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_meta = 2'd1,
        e_wait = 2'd2
    } state_e;

    state_e                      r_state;
    logic                        r_owner;
    logic                        r_last_grant;
    logic [metadata_width_p-1:0] r_metadata;

    logic w_idle;
    logic w_busy;
    logic w_sel;
    logic w_handshake;

    // Every output is gated by reset_i so nothing leaks out while reset is held,
    // even before the first reset edge has cleared the state.
    assign w_idle      = (r_state == e_idle) && !reset_i;
    assign w_busy      = (r_state != e_idle) && !reset_i;
    assign w_sel       = (req0_v_i && req1_v_i) ? ~r_last_grant : req1_v_i;
    assign w_handshake = w_idle && (req0_v_i || req1_v_i) && cache_req_ready_i;

    assign cache_req_v_o = w_handshake;
    assign cache_req_o   = reset_i ? '0 : (w_sel ? req1_i : req0_i);
    assign req0_yumi_o   = w_handshake && !w_sel;
    assign req1_yumi_o   = w_handshake &&  w_sel;

    assign cache_req_metadata_v_o = (r_state == e_meta) && !reset_i;
    assign cache_req_metadata_o   = reset_i ? '0 : r_metadata;

    assign req0_critical_o = w_busy && !r_owner && cache_req_critical_i;
    assign req1_critical_o = w_busy &&  r_owner && cache_req_critical_i;
    assign req0_complete_o = w_busy && !r_owner && cache_req_complete_i;
    assign req1_complete_o = w_busy &&  r_owner && cache_req_complete_i;

    assign busy_o = w_busy;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= e_idle;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_metadata   <= '0;
        end else begin
            case (r_state)
                e_idle: begin
                    if (w_handshake) begin
                        r_state      <= e_meta;
                        r_owner      <= w_sel;
                        r_last_grant <= w_sel;
                        r_metadata   <= w_sel ? req1_metadata_i : req0_metadata_i;
                    end
                end
                e_meta:  r_state <= cache_req_complete_i ? e_idle : e_wait;
                e_wait: begin
                    if (cache_req_complete_i) r_state <= e_idle;
                end
                default: r_state <= e_idle;
            endcase
        end
    end

endmodule

// File: doc/bp_be_cache_req_arbiter.md
# bp_be_cache_req_arbiter

Shares the backend's single D$-to-LCE miss request channel (cache_req / cache_req_metadata / critical / complete) between two requesters: requester 0 is the D$ miss path, requester 1 is the page-table walker / uncached path. The block grants one request at a time, emits its metadata one cycle after the request handshake, and tracks the outstanding transaction. It steers cache_req_critical_i and cache_req_complete_i back to the owning requester. It sits between bp_be_calculator_top's memory pipe and the LCE ports of bp_be_top.

## Interface
Parameters:
- req_width_p, 128, packed cache request width (dcache_req_width_lp).
- metadata_width_p, 8, packed request metadata width (dcache_req_metadata_width_lp).

Ports:
- clk_i  in  1  clock; every register updates on its rising edge.
- reset_i  in  1  reset; synchronous, active-high.
- req0_i  in  req_width_p  requester 0 request.
- req0_metadata_i  in  metadata_width_p  requester 0 metadata, sampled at the grant.
- req0_v_i  in  1  requester 0 valid.
- req0_yumi_o  out  1  requester 0 request accepted this cycle.
- req0_critical_o  out  1  critical data returned for requester 0.
- req0_complete_o  out  1  requester 0 transaction complete.
- req1_i, req1_metadata_i, req1_v_i, req1_yumi_o, req1_critical_o, req1_complete_o: same as the requester 0 ports, for requester 1.
- cache_req_o  out  req_width_p  request to LCE.
- cache_req_v_o  out  1  request valid.
- cache_req_ready_i  in  1  LCE ready; the handshake completes when ready & v.
- cache_req_metadata_o  out  metadata_width_p  latched metadata.
- cache_req_metadata_v_o  out  1  metadata valid.
- cache_req_critical_i  in  1  LCE critical-word return.
- cache_req_complete_i  in  1  LCE transaction done.
- busy_o  out  1  a transaction is outstanding (state ≠ e_idle).

## Operation
- FSM states are e_idle, e_meta and e_wait. Registers:
  - state
  - owner (1 bit)
  - metadata_r (metadata_width_p)
  - last_grant (1 bit)
- e_idle:
  - A candidate exists when req0_v_i | req1_v_i.
  - When only one requester is valid, it is selected.
  - When both are valid, the requester ≠ last_grant is selected (round-robin).
  - cache_req_v_o = candidate exists & cache_req_ready_i. cache_req_o is the selected requester's request.
  - On the handshake:
    - the selected requester's yumi pulses;
    - owner and last_grant are set to the selected requester;
    - metadata_r is loaded from the selected requester's metadata;
    - the FSM moves to e_meta.
- e_meta:
  - cache_req_metadata_v_o = 1 for exactly this cycle.
  - Next state is e_idle if cache_req_complete_i, else e_wait.
- e_wait: the FSM holds until cache_req_complete_i, then moves to e_idle.
- In e_meta and e_wait:
  - cache_req_critical_i and cache_req_complete_i are forwarded combinationally to req<owner>_critical_o and req<owner>_complete_o. The other requester's outputs stay 0.
  - cache_req_v_o = 0 and both yumis = 0: only one transaction is ever outstanding.
- In e_idle, critical_i and complete_i are ignored: all critical/complete outputs are 0.
- A requester must hold req/v stable until its yumi. The arbiter never yumis a requester whose v is low.
- Reset values (reset_i is sampled at the clock edge):
  - state = e_idle, owner = 0, last_grant = 1 (requester 0 wins the first tie), metadata_r = 0.
  - Every output is 0 while reset_i is high, including cache_req_v_o and both yumis.
- Reset mid-transaction abandons the transaction. Requesters and the LCE are reset together.

## Timing
- Grant latency: cache_req_v_o and the yumi are combinational in the same cycle as req_v and ready. There is no request register.
- Metadata: valid exactly 1 cycle after the request handshake, with the value sampled at the handshake.
- Minimum occupancy:
  - handshake cycle N;
  - e_meta in cycle N+1, with complete_i possible in N+1;
  - e_idle in cycle N+2, where the next grant is possible.
- Back-to-back grants are never closer than 2 cycles apart.
- critical_o and complete_o are zero-latency pass-throughs, qualified by state and owner.
- busy_o is high in cycles N+1 up to and including the cycle in which complete_i is seen.

## Test plan
- Single request: req0_v_i=1, req0_i=0xA5, metadata=0x3, ready=1 in cycle 0 -> cycle 0: cache_req_v_o=1, cache_req_o=0xA5, req0_yumi_o=1; cycle 1: cache_req_metadata_v_o=1, metadata=0x3; complete_i in cycle 4 -> req0_complete_o=1 in cycle 4, busy_o=0 in cycle 5.
- Contention/round-robin: both v held high, complete_i 1 cycle after each metadata -> grants alternate 0,1,0,1; the first grant after reset goes to 0.
- Not ready: req1_v_i=1, ready=0 for 3 cycles -> cache_req_v_o=0 and req1_yumi_o=0 for those cycles; grant in the first cycle with ready=1.
- Routing: owner=1, critical_i in cycle 2 and complete_i in cycle 5 -> req1_critical_o and req1_complete_o pulse in those cycles; req0_* stay 0. A new req0_v_i is not yumi'd before cycle 6.
- Complete during metadata: complete_i in the e_meta cycle -> the FSM returns to e_idle the next cycle and a pending req is granted that cycle. Spurious complete_i in e_idle -> no output.
- Reset mid-operation: reset_i asserted in e_wait -> the next cycle has state e_idle, busy_o=0 and all outputs 0; after reset, with both requesters valid, requester 0 is granted.
